// File: rtl/skinny_sbox8_isw1_sequencer.sv
// Sequencer for a two-share 8-bit ISW S-box: latches shares, then a fresh mask,
// holds them stable for LATENCY edges and captures the S-box output shares.
module skinny_sbox8_isw1_sequencer #(
    parameter int unsigned LATENCY = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_s0,
    input  logic [7:0] in_s1,
    input  logic       rnd_valid,
    output logic       rnd_ready,
    input  logic [7:0] rnd,
    output logic [7:0] sb_si0,
    output logic [7:0] sb_si1,
    output logic [7:0] sb_r,
    input  logic [7:0] sb_bo0,
    input  logic [7:0] sb_bo1,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_s0,
    output logic [7:0] out_s1,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RAND = 2'd1,
        EVAL = 2'd2,
        OUT  = 2'd3
    } state_t;

    localparam logic [3:0] CNT_LAST = 4'(LATENCY - 1);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       load_in, load_rnd, load_out;

    logic [7:0] si0_q, si1_q, r_q, o0_q, o1_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        load_in  = 1'b0;
        load_rnd = 1'b0;
        load_out = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    load_in = 1'b1;
                    state_d = RAND;
                end
            end
            RAND: begin
                if (rnd_valid) begin
                    load_rnd = 1'b1;
                    cnt_d    = 4'd0;
                    state_d  = EVAL;
                end
            end
            EVAL: begin
                if (cnt_q == CNT_LAST) begin
                    load_out = 1'b1;
                    state_d  = OUT;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            OUT: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Each share travels through its own registers; shares are never mixed here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            si0_q <= 8'h00;
            o0_q  <= 8'h00;
        end else begin
            if (load_in)  si0_q <= in_s0;
            if (load_out) o0_q  <= sb_bo0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            si1_q <= 8'h00;
            o1_q  <= 8'h00;
        end else begin
            if (load_in)  si1_q <= in_s1;
            if (load_out) o1_q  <= sb_bo1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= 8'h00;
        end else if (load_rnd) begin
            r_q <= rnd;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign rnd_ready = (state_q == RAND);
    assign out_valid = (state_q == OUT);
    assign busy      = (state_q != IDLE);

    assign sb_si0 = si0_q;
    assign sb_si1 = si1_q;
    assign sb_r   = r_q;
    assign out_s0 = o0_q;
    assign out_s1 = o1_q;

endmodule

// File: tb/tb_skinny_sbox8_isw1_sequencer.sv
// Randomised bench: a behavioural two-share S-box that only yields correct shares
// after LATENCY stable edges, checked against the SKINNY-128 8-bit S-box.
module tb_skinny_sbox8_isw1_sequencer;

    localparam int LAT = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, rnd_valid, out_ready;
    logic [7:0] in_s0, in_s1, rnd;
    logic       in_ready, rnd_ready, out_valid, busy;
    logic [7:0] sb_si0, sb_si1, sb_r, sb_bo0, sb_bo1, out_s0, out_s1;

    int n_cmp = 0;
    int n_err = 0;
    int hs_count = 0;
    int masks_given = 0;

    skinny_sbox8_isw1_sequencer #(.LATENCY(LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_s0(in_s0), .in_s1(in_s1),
        .rnd_valid(rnd_valid), .rnd_ready(rnd_ready), .rnd(rnd),
        .sb_si0(sb_si0), .sb_si1(sb_si1), .sb_r(sb_r),
        .sb_bo0(sb_bo0), .sb_bo1(sb_bo1),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_s0(out_s0), .out_s1(out_s1), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mix(input logic [7:0] x);
        return (~(((x >> 1) | x) >> 2) & 8'h11) ^ x;
    endfunction

    function automatic logic [7:0] perm(input logic [7:0] x);
        return ((x & 8'h01) << 2) | ((x & 8'h06) << 5) | ((x & 8'h20) >> 5) |
               ((x & 8'hC8) >> 2) | ((x & 8'h10) >> 1);
    endfunction

    function automatic logic [7:0] skinny_sbox(input logic [7:0] v);
        logic [7:0] x;
        x = mix(v);
        x = mix(perm(x));
        x = mix(perm(x));
        x = mix(perm(x));
        return (x & 8'hF9) | ((x >> 1) & 8'h02) | ((x << 1) & 8'h04);
    endfunction

    // S-box model: output shares are only right once inputs have been stable long enough.
    logic [23:0] prev_in = 24'h0;
    int          stab = 0;
    always @(negedge clk) begin
        if ({sb_si0, sb_si1, sb_r} !== prev_in) stab <= 0;
        else if (stab < 1000) stab <= stab + 1;
        prev_in <= {sb_si0, sb_si1, sb_r};
    end
    assign sb_bo0 = (stab >= LAT - 1) ? (skinny_sbox(sb_si0 ^ sb_si1) ^ sb_r)
                                      : (~skinny_sbox(sb_si0 ^ sb_si1) ^ sb_r);
    assign sb_bo1 = sb_r;

    always @(posedge clk) begin
        if (rst_n && rnd_valid && rnd_ready) hs_count <= hs_count + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_out_valid"}, out_valid, 1'b0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_rnd_ready"}, rnd_ready, 1'b0);
        chk({tag, "_in_ready"}, in_ready, 1'b1);
        chk({tag, "_sb"}, {sb_si0, sb_si1, sb_r}, 24'h0);
        chk({tag, "_out"}, {out_s0, out_s1}, 16'h0);
    endtask

    // One operation, entered and left at a negedge with the block in IDLE.
    task automatic do_op(input logic [7:0] s0, input logic [7:0] s1, input logic [7:0] r,
                         input int igap, input int rgap, input int ogap, input int abort_at,
                         output logic [7:0] res);
        logic [7:0] o0, o1;
        int lat;
        res = 8'h00;
        for (int k = 0; k < igap; k++) begin
            chk("idle_rnd_ready", rnd_ready, 1'b0);
            rnd_valid = 1'($urandom); rnd = 8'($urandom); out_ready = 1'($urandom);
            @(negedge clk);
        end
        chk("in_ready", in_ready, 1'b1);
        chk("idle_busy", busy, 1'b0);
        in_valid = 1'b1; in_s0 = s0; in_s1 = s1; rnd_valid = 1'b0;
        @(negedge clk);
        in_valid = 1'($urandom); in_s0 = 8'($urandom); in_s1 = 8'($urandom);
        for (int k = 0; k < rgap; k++) begin
            chk("rand_wait_ready", rnd_ready, 1'b1);
            chk("rand_wait_busy", busy, 1'b1);
            rnd_valid = 1'b0; rnd = 8'($urandom);
            @(negedge clk);
        end
        chk("rnd_ready", rnd_ready, 1'b1);
        rnd_valid = 1'b1; rnd = r; masks_given++;
        @(negedge clk);
        lat = 0;
        while (out_valid !== 1'b1 && lat < LAT + 4) begin
            chk("eval_sb", {sb_si0, sb_si1, sb_r}, {s0, s1, r});
            chk("eval_ready", {in_ready, rnd_ready}, 2'b00);
            if (lat == abort_at) begin
                rst_n = 1'b0;
                #1;
                chk_reset_outputs("abort");
                in_valid = 1'b1; rnd_valid = 1'b1; out_ready = 1'b1;
                repeat (2) @(negedge clk);
                chk_reset_outputs("held_reset");
                in_valid = 1'b0; rnd_valid = 1'b0; out_ready = 1'b0;
                rst_n = 1'b1;
                @(negedge clk);
                chk_reset_outputs("after_abort");
                return;
            end
            in_valid = 1'($urandom); rnd_valid = 1'($urandom); rnd = 8'($urandom);
            out_ready = 1'($urandom);
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, LAT);
        o0 = out_s0; o1 = out_s1; res = o0 ^ o1;
        chk("result", res, skinny_sbox(s0 ^ s1));
        for (int k = 0; k < ogap; k++) begin
            chk("hold_valid", out_valid, 1'b1);
            chk("hold_out", {out_s0, out_s1}, {o0, o1});
            chk("hold_in_ready", in_ready, 1'b0);
            chk("hold_sb", {sb_si0, sb_si1, sb_r}, {s0, s1, r});
            out_ready = 1'b0; in_valid = 1'($urandom); rnd_valid = 1'($urandom);
            @(negedge clk);
        end
        chk("out_valid", out_valid, 1'b1);
        out_ready = 1'b1; in_valid = 1'b0; rnd_valid = 1'b0;
        @(negedge clk);
        out_ready = 1'b0;
        chk("back_idle", {in_ready, out_valid, busy}, 3'b100);
    endtask

    initial begin
        logic [7:0] res, a, v;
        rst_n = 1'b0; in_valid = 1'b0; rnd_valid = 1'b0; out_ready = 1'b0;
        in_s0 = 8'h00; in_s1 = 8'h00; rnd = 8'h00;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);
        chk_reset_outputs("post_reset");

        do_op(8'h5A, 8'h5A, 8'h3C, 0, 0, 0, -1, res);
        chk("vec_5a5a", res, 8'h65);
        do_op(8'hC3, 8'h3C, 8'($urandom), 1, 5, 0, -1, res);
        chk("vec_c33c", res, 8'hFF);
        a = 8'($urandom);
        do_op(a, a ^ 8'h12, 8'($urandom), 0, 0, 10, -1, res);
        do_op(8'($urandom), 8'($urandom), 8'($urandom), 0, 0, 0, 4, res);
        a = 8'($urandom);
        do_op(a, a, 8'($urandom), 0, 0, 0, -1, res);
        chk("vec_after_abort", res, 8'h65);

        for (int i = 0; i < 256; i++) begin
            a = 8'($urandom);
            v = 8'(i);
            do_op(a, a ^ v, 8'($urandom), $urandom_range(0, 2), $urandom_range(0, 3),
                  $urandom_range(0, 3), -1, res);
        end

        @(negedge clk);
        chk("mask_count", hs_count, masks_given);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
